sweep_scheduler: RTL and testbench
==================================

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1000: clocks to wait after each servo step before sampling.
REQ-002 SHALL have parameter SAMPLES_PER_STEP, default 4: EOC pulses accepted per step position.
REQ-003 SHALL have parameter MOVE_CYC, default 50000: clocks MC is held so the servos reach the stored maximum.
REQ-004 SHALL have parameter PERIOD_CYC, default 100000000: idle clocks between automatic re-tracks.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port START, input, 1, pulse requesting one tracking cycle.
REQ-008 SHALL have port ABORT, input, 1, level forcing return to idle.
REQ-009 SHALL have port AUTO, input, 1, enables periodic re-track.
REQ-010 SHALL have port EOC, input, 1, ADC end-of-conversion strobe.
REQ-011 SHALL have ports PWM_LIMIT_H and PWM_LIMIT_V, input, 1 each, servo at its sweep end.
REQ-012 SHALL have ports HS, VS and MC, output, 1 each, horizontal sweep, vertical sweep and move-to-max enables.
REQ-013 SHALL have port STEP, output, 1, one-clock pulse advancing the active servo one position.
REQ-014 SHALL have port SAMPLE_EN, output, 1, qualifies comparator/max-register capture.
REQ-015 SHALL have port CNT_RST, output, 1, one-clock pulse clearing the max register at cycle start.
REQ-016 SHALL have ports BUSY and DONE, output, 1 each; BUSY is high outside idle, DONE is a one-clock pulse when a cycle completes.
REQ-017 SHALL have port STAT, output, 3, current state encoding.

Function
REQ-018 SHALL implement states IDLE=0, H_STEP=1, H_SETTLE=2, H_SAMPLE=3, V_STEP=4, V_SETTLE=5, V_SAMPLE=6, MOVE_MAX=7, with STAT equal to the state code.
REQ-019 SHALL leave IDLE for H_SETTLE on START, or on period-timer expiry when AUTO=1, asserting CNT_RST on that transition clock.
REQ-020 SHALL stay in H_SETTLE/V_SETTLE exactly SETTLE_CYC clocks, then enter the matching SAMPLE state.
REQ-021 SHALL count EOC pulses in SAMPLE states only, drive SAMPLE_EN=1 only there, and leave after the SAMPLE_PER_STEP-th EOC.
REQ-022 SHALL, on leaving H_SAMPLE: go to V_SETTLE if PWM_LIMIT_H=1, else to H_STEP.
REQ-023 SHALL, on leaving V_SAMPLE: go to MOVE_MAX if PWM_LIMIT_V=1, else to V_STEP.
REQ-024 SHALL have H_STEP/V_STEP last one clock with STEP=1, then return to the matching SETTLE state.
REQ-025 SHALL drive HS=1 in states 1-3, VS=1 in 4-6 and MC=1 in 7; at most one is high.
REQ-026 SHALL hold MOVE_MAX for MOVE_CYC clocks, then pulse DONE and enter IDLE.
REQ-027 SHALL count the period timer only in IDLE with AUTO=1, clear it on leaving IDLE or when AUTO=0, and expire at PERIOD_CYC-1.
REQ-028 SHALL, on ABORT=1 in any state, enter IDLE next clock with no DONE; ABORT wins over a simultaneous START.
REQ-029 SHALL ignore START while BUSY=1.
REQ-030 SHALL ignore EOC outside SAMPLE states; an EOC coinciding with SAMPLE entry is not counted.
REQ-031 SHALL use 32-bit unsigned counters with compare-on-equality, no wrap; parameters are legal only when >= 1.

Reset
REQ-032 SHALL, while RST=0, force IDLE, all counters to 0 and HS=VS=MC=STEP=SAMPLE_EN=CNT_RST=BUSY=DONE=0, STAT=0.
REQ-033 SHALL abandon a cycle immediately when reset is asserted mid-operation, and start no cycle on release without START or timer expiry.

Structure
REQ-034 SHALL place the state encoding and parameter defaults in shared package sweep_pkg.
REQ-035 SHALL use one sub-module, cycle_timer (load, count, done), for the settle, move and period delays.

Verification (SETTLE_CYC=3, SAMPLES_PER_STEP=2, MOVE_CYC=5, PERIOD_CYC=20)
REQ-036 SHALL check that a START pulse with PWM_LIMIT_H set after 2 steps and PWM_LIMIT_V after 1 step gives STEP=3 pulses in total, CNT_RST once and DONE once, then STAT=0.
REQ-037 SHALL check that with EOC every clock, each SAMPLE state lasts exactly 2 clocks and each SETTLE state exactly 3 clocks.
REQ-038 SHALL check that ABORT in V_SETTLE gives STAT=0 next clock, no DONE and all enables low.
REQ-039 SHALL check that AUTO=1 in idle starts a cycle 20 clocks later with CNT_RST; AUTO dropped at clock 10 starts none.
REQ-040 SHALL check that START during H_SAMPLE is ignored, and that simultaneous START and ABORT in IDLE stay in IDLE.
REQ-041 SHALL check that asserting RST low during MOVE_MAX clears MC and BUSY asynchronously with STAT=0.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared state encoding and parameter defaults for the tracking sweep scheduler.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    H_STEP   = 3'd1,
    H_SETTLE = 3'd2,
    H_SAMPLE = 3'd3,
    V_STEP   = 3'd4,
    V_SETTLE = 3'd5,
    V_SAMPLE = 3'd6,
    MOVE_MAX = 3'd7
  } state_t;

  localparam int unsigned CNT_W                = 32;
  localparam int unsigned SETTLE_CYC_DEF       = 1000;
  localparam int unsigned SAMPLES_PER_STEP_DEF = 4;
  localparam int unsigned MOVE_CYC_DEF         = 50000;
  localparam int unsigned PERIOD_CYC_DEF       = 100000000;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear; done flags the last counted event before limit.
module cycle_timer
  import sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             count,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end

  // Independent of load, so the caller may derive load from done without a loop.
  assign done = count && (cnt == limit - 1'b1);

endmodule

// File: rtl/sweep_scheduler.sv
// Sequencer for a two-axis sun-tracking sweep: H sweep, V sweep, then move to stored max.
module sweep_scheduler
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYC       = SETTLE_CYC_DEF,
  parameter int unsigned SAMPLES_PER_STEP = SAMPLES_PER_STEP_DEF,
  parameter int unsigned MOVE_CYC         = MOVE_CYC_DEF,
  parameter int unsigned PERIOD_CYC       = PERIOD_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       AUTO,
  input  logic       EOC,
  input  logic       PWM_LIMIT_H,
  input  logic       PWM_LIMIT_V,
  output logic       HS,
  output logic       VS,
  output logic       MC,
  output logic       STEP,
  output logic       SAMPLE_EN,
  output logic       CNT_RST,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] STAT
);

  state_t           state, state_nxt;
  logic             phase_load, phase_count, phase_done;
  logic [CNT_W-1:0] phase_limit;
  logic             period_load, period_count, period_done;
  logic             cnt_rst_c, done_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // One phase timer serves settle, sample (counting EOC) and move; it restarts on every state change.
  always_comb begin
    phase_count = 1'b0;
    phase_limit = CNT_W'(SETTLE_CYC);
    case (state)
      H_SETTLE, V_SETTLE: phase_count = 1'b1;
      H_SAMPLE, V_SAMPLE: begin
        phase_count = EOC;
        phase_limit = CNT_W'(SAMPLES_PER_STEP);
      end
      MOVE_MAX: begin
        phase_count = 1'b1;
        phase_limit = CNT_W'(MOVE_CYC);
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_rst_c = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (START || period_done) begin
        state_nxt = H_SETTLE;
        cnt_rst_c = 1'b1;
      end
      H_STEP:   state_nxt = H_SETTLE;
      V_STEP:   state_nxt = V_SETTLE;
      H_SETTLE: if (phase_done) state_nxt = H_SAMPLE;
      V_SETTLE: if (phase_done) state_nxt = V_SAMPLE;
      H_SAMPLE: if (phase_done) state_nxt = PWM_LIMIT_H ? V_SETTLE : H_STEP;
      V_SAMPLE: if (phase_done) state_nxt = PWM_LIMIT_V ? MOVE_MAX : V_STEP;
      MOVE_MAX: if (phase_done) begin
        state_nxt = IDLE;
        done_c    = 1'b1;
      end
      default:  state_nxt = IDLE;
    endcase
    if (ABORT) begin
      state_nxt = IDLE;
      cnt_rst_c = 1'b0;
      done_c    = 1'b0;
    end
  end

  assign phase_load   = (state_nxt != state);
  assign period_count = (state == IDLE) && AUTO;
  assign period_load  = !period_count || (state_nxt != IDLE);

  cycle_timer u_phase_timer (
    .clk   (CLK),
    .rst_n (RST),
    .load  (phase_load),
    .count (phase_count),
    .limit (phase_limit),
    .done  (phase_done)
  );

  cycle_timer u_period_timer (
    .clk   (CLK),
    .rst_n (RST),
    .load  (period_load),
    .count (period_count),
    .limit (CNT_W'(PERIOD_CYC)),
    .done  (period_done)
  );

  assign HS        = (state == H_STEP) || (state == H_SETTLE) || (state == H_SAMPLE);
  assign VS        = (state == V_STEP) || (state == V_SETTLE) || (state == V_SAMPLE);
  assign MC        = (state == MOVE_MAX);
  assign STEP      = (state == H_STEP) || (state == V_STEP);
  assign SAMPLE_EN = (state == H_SAMPLE) || (state == V_SAMPLE);
  assign BUSY      = (state != IDLE);
  assign STAT      = state;
  // START is combinational into CNT_RST, so it must be held off while reset is low.
  assign CNT_RST   = cnt_rst_c && RST;
  assign DONE      = done_c;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: a cycle-by-cycle vector table plus corner-case sequences.
module tb_sweep_scheduler;

  logic       CLK = 1'b0;
  logic       RST, START, ABORT, AUTO, EOC, PWM_LIMIT_H, PWM_LIMIT_V;
  logic       HS, VS, MC, STEP, SAMPLE_EN, CNT_RST, BUSY, DONE;
  logic [2:0] STAT;

  always #5 CLK = ~CLK;

  sweep_scheduler #(
    .SETTLE_CYC       (3),
    .SAMPLES_PER_STEP (2),
    .MOVE_CYC         (5),
    .PERIOD_CYC       (20)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .ABORT       (ABORT),
    .AUTO        (AUTO),
    .EOC         (EOC),
    .PWM_LIMIT_H (PWM_LIMIT_H),
    .PWM_LIMIT_V (PWM_LIMIT_V),
    .HS          (HS),
    .VS          (VS),
    .MC          (MC),
    .STEP        (STEP),
    .SAMPLE_EN   (SAMPLE_EN),
    .CNT_RST     (CNT_RST),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .STAT        (STAT)
  );

  // stim = {START, ABORT, AUTO, EOC, PWM_LIMIT_H, PWM_LIMIT_V}
  // want = {STAT, HS, VS, MC, STEP, SAMPLE_EN, CNT_RST, BUSY, DONE}
  typedef struct packed {
    logic [5:0]  stim;
    logic [10:0] want;
  } vec_t;

  localparam logic [7:0] F_IDLE = 8'b0000_0000;
  localparam logic [7:0] F_GO   = 8'b0000_0100;
  localparam logic [7:0] F_HSET = 8'b1000_0010;
  localparam logic [7:0] F_HSAM = 8'b1000_1010;
  localparam logic [7:0] F_HSTP = 8'b1001_0010;
  localparam logic [7:0] F_VSET = 8'b0100_0010;
  localparam logic [7:0] F_VSAM = 8'b0100_1010;
  localparam logic [7:0] F_VSTP = 8'b0101_0010;
  localparam logic [7:0] F_MOVE = 8'b0010_0010;
  localparam logic [7:0] F_MEND = 8'b0010_0011;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {STAT, HS, VS, MC, STEP, SAMPLE_EN, CNT_RST, BUSY, DONE};
  endfunction

  task automatic seg(input int n, input logic [5:0] stim, input logic [2:0] st,
                     input logic [7:0] fl);
    repeat (n) vecs.push_back({stim, st, fl});
  endtask

  task automatic drive(input logic [5:0] stim);
    {START, ABORT, AUTO, EOC, PWM_LIMIT_H, PWM_LIMIT_V} = stim;
  endtask

  // Polls STAT once per cycle at the sampling point; an expired budget is a failed comparison.
  task automatic wait_stat(input logic [2:0] target, input int budget);
    int k = 0;
    while (STAT !== target && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check($sformatf("wait_stat_%0d", target), 32'(STAT), 32'(target));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_step, n_cnt_rst, n_done, cyc, hits;

    // Reset: START held high must not leak through CNT_RST.
    RST = 1'b0;
    drive(6'b100000);
    @(negedge CLK);
    #1 check("reset_outputs", 32'(obs()), 32'd0);
    RST = 1'b1;
    drive(6'b000000);
    repeat (3) @(negedge CLK);
    #1 check("idle_after_release", 32'({STAT, BUSY}), 32'd0);

    // Full track: two H steps before the H limit, one V step before the V limit, EOC every clock.
    seg(1, 6'b100100, 3'd0, F_GO);
    seg(3, 6'b000100, 3'd2, F_HSET);
    seg(2, 6'b000100, 3'd3, F_HSAM);
    seg(1, 6'b000100, 3'd1, F_HSTP);
    seg(3, 6'b000100, 3'd2, F_HSET);
    seg(2, 6'b000100, 3'd3, F_HSAM);
    seg(1, 6'b000100, 3'd1, F_HSTP);
    seg(3, 6'b000100, 3'd2, F_HSET);
    seg(1, 6'b000100, 3'd3, F_HSAM);
    seg(1, 6'b000110, 3'd3, F_HSAM);
    seg(3, 6'b000110, 3'd5, F_VSET);
    seg(2, 6'b000110, 3'd6, F_VSAM);
    seg(1, 6'b000110, 3'd4, F_VSTP);
    seg(3, 6'b000110, 3'd5, F_VSET);
    seg(1, 6'b000110, 3'd6, F_VSAM);
    seg(1, 6'b000111, 3'd6, F_VSAM);
    seg(4, 6'b000111, 3'd7, F_MOVE);
    seg(1, 6'b000111, 3'd7, F_MEND);
    seg(1, 6'b000111, 3'd0, F_IDLE);

    n_step = 0; n_cnt_rst = 0; n_done = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].stim);
      #1;
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].want));
      if (STEP)    n_step++;
      if (CNT_RST) n_cnt_rst++;
      if (DONE)    n_done++;
    end
    check("step_total", n_step, 3);
    check("cnt_rst_total", n_cnt_rst, 1);
    check("done_total", n_done, 1);

    // ABORT in V_SETTLE.
    @(negedge CLK); drive(6'b100110);
    @(negedge CLK); drive(6'b000110);
    wait_stat(3'd5, 20);
    @(negedge CLK); drive(6'b010110);
    #1 check("abort_no_done", 32'(DONE), 32'd0);
    @(negedge CLK); drive(6'b000000);
    #1 check("abort_to_idle", 32'(obs()), 32'd0);

    // AUTO held: the period expires on the 20th idle clock with AUTO high.
    @(negedge CLK); drive(6'b001000);
    #1;
    cyc = 0;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      if (CNT_RST) cyc = c;
      else begin
        @(negedge CLK);
        #1;
      end
    end
    check("auto_expiry_cycle", cyc, 20);
    @(negedge CLK);
    #1 check("auto_started", 32'(STAT), 32'd2);
    @(negedge CLK); drive(6'b010000);
    @(negedge CLK); drive(6'b000000);

    // AUTO dropped at clock 10: no cycle may start.
    @(negedge CLK); drive(6'b001000);
    repeat (9) @(negedge CLK);
    drive(6'b000000);
    hits = 0;
    repeat (30) begin
      #1 if (CNT_RST || BUSY) hits++;
      @(negedge CLK);
    end
    check("auto_dropped_no_start", hits, 0);

    // START during H_SAMPLE is ignored and the sample count carries on.
    @(negedge CLK); drive(6'b100000);
    @(negedge CLK); drive(6'b000000);
    wait_stat(3'd3, 10);
    @(negedge CLK); drive(6'b100000);
    #1 check("start_in_sample_cnt_rst", 32'(CNT_RST), 32'd0);
    @(negedge CLK); drive(6'b000000);
    #1 check("start_in_sample_stat", 32'(STAT), 32'd3);
    @(negedge CLK); drive(6'b000100);
    @(negedge CLK);
    @(negedge CLK); drive(6'b000000);
    #1 check("sample_exit_to_step", 32'(STAT), 32'd1);
    @(negedge CLK); drive(6'b010000);
    @(negedge CLK); drive(6'b110000);
    #1 check("start_abort_cnt_rst", 32'(CNT_RST), 32'd0);
    @(negedge CLK); drive(6'b000000);
    #1 check("start_abort_idle", 32'({STAT, BUSY}), 32'd0);

    // Reset asserted mid MOVE_MAX clears outputs before the next clock edge.
    @(negedge CLK); drive(6'b100111);
    @(negedge CLK); drive(6'b000111);
    wait_stat(3'd7, 30);
    #2 RST = 1'b0;
    #1 check("rst_async_move", 32'({STAT, MC, BUSY}), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    drive(6'b000000);
    repeat (3) @(negedge CLK);
    #1 check("rst_release_idle", 32'({STAT, BUSY}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
